cache_mem_arbiter: RTL and testbench

// - Shares the single physical-memory port between the instruction cache (fetch miss path) and the data cache (MEM-stage miss/writeback path).
// - Sits between the two L1 caches and pmem. Its resp timing drives icache_stall and mem_stall, and so the pipeline stall logic.
// - Round-robin on conflict, so neither the fetch stage nor the MEM stage is starved.
// - One outstanding pmem transaction at a time; saturating per-requester grant/conflict counters for performance work.

---
 rtl/cache_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares the single physical-memory port between the instruction cache
//   (fetch miss path) and the data cache (MEM-stage fill/writeback path).
//   One pmem transaction is outstanding at a time. Conflicts are resolved
//   round-robin so neither pipeline stage starves. Saturating counters
//   record grants per requester and IDLE cycles in which both sides request.
//
// Handshake (all three links):
//   A requester raises read/write and holds it, address and wdata stable,
//   until it sees its one-cycle resp pulse. resp is the only completion
//   indication. rdata is valid only in the resp cycle. Downstream, the
//   pmem_read/pmem_write strobe stays high until pmem_resp is seen.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   i_mem_read/address         icache fill request and line address
//   i_mem_rdata/resp           fill data and completion to icache
//   d_mem_read/write/address   dcache fill / writeback request
//   d_mem_wdata                dcache writeback line
//   d_mem_rdata/resp           fill data and completion to dcache
//   pmem_read/write            downstream strobes (registered)
//   pmem_address/wdata         downstream address / write line (registered)
//   pmem_rdata/resp            downstream read line and completion
//   perf_clear                 synchronous clear of the perf counters
//   perf_i_grants/d_grants     saturating grant counters
//   perf_conflicts             saturating count of IDLE conflict cycles
//   dbg_state                  current FSM state (0 IDLE, 1 SERVE_I, 2 SERVE_D)
module cache_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  input  logic              perf_clear,
  output logic [CNT_W-1:0]  perf_i_grants,
  output logic [CNT_W-1:0]  perf_d_grants,
  output logic [CNT_W-1:0]  perf_conflicts,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic              op_write_q;
  logic              last_was_d_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  logic i_req, d_req;
  logic grant_i, grant_d, conflict;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

  // Next state, grant decision and completion routing.
  always_comb begin
    state_d    = state_q;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    conflict   = 1'b0;
    i_mem_resp = 1'b0;
    d_mem_resp = 1'b0;
    case (state_q)
      IDLE: begin
        conflict = i_req & d_req;
        if (i_req && d_req) begin
          // Alternate: whoever was not granted last wins the tie.
          if (last_was_d_q) grant_i = 1'b1;
          else              grant_d = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end
        if (grant_d)      state_d = SERVE_D;
        else if (grant_i) state_d = SERVE_I;
      end
      SERVE_I: begin
        if (pmem_resp) begin
          i_mem_resp = 1'b1;
          state_d    = IDLE;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          d_mem_resp = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured transaction. A stale pmem_resp seen in IDLE falls
  // through the case above and is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_write_q   <= 1'b0;
      last_was_d_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        addr_q       <= d_mem_address;
        wdata_q      <= d_mem_wdata;
        // read+write together is illegal; it resolves as a write.
        op_write_q   <= d_mem_write;
        last_was_d_q <= 1'b1;
      end else if (grant_i) begin
        addr_q       <= i_mem_address;
        wdata_q      <= d_mem_wdata;
        op_write_q   <= 1'b0;
        last_was_d_q <= 1'b0;
      end
    end
  end

  // Perf counters: clear beats a same-cycle increment; hold at all-ones.
  always_ff @(posedge clk) begin
    if (reset || perf_clear) begin
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (grant_i && perf_i_grants != CNT_MAX)
        perf_i_grants <= perf_i_grants + CNT_W'(1);
      if (grant_d && perf_d_grants != CNT_MAX)
        perf_d_grants <= perf_d_grants + CNT_W'(1);
      if (conflict && perf_conflicts != CNT_MAX)
        perf_conflicts <= perf_conflicts + CNT_W'(1);
    end
  end

  // Downstream side is driven only from registered state.
  assign pmem_read    = (state_q != IDLE) & ~op_write_q;
  assign pmem_write   = (state_q != IDLE) &  op_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_mem_rdata = pmem_rdata;
  assign d_mem_rdata = pmem_rdata;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  // Narrow counters so the saturation point is reachable in a short run.
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_address;
  logic [LINE_W-1:0] i_mem_rdata;
  logic              i_mem_resp;
  logic              d_mem_read, d_mem_write;
  logic [ADDR_W-1:0] d_mem_address;
  logic [LINE_W-1:0] d_mem_wdata, d_mem_rdata;
  logic              d_mem_resp;
  logic              pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata, pmem_rdata;
  logic              pmem_resp;
  logic              perf_clear;
  logic [CNT_W-1:0]  perf_i_grants, perf_d_grants, perf_conflicts;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .perf_clear(perf_clear), .perf_i_grants(perf_i_grants),
    .perf_d_grants(perf_d_grants), .perf_conflicts(perf_conflicts),
    .dbg_state(dbg_state)
  );

  always @(posedge clk) begin
    assert (!(d_mem_read && d_mem_write)) else $error("illegal dcache read+write");
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int checks = 0;
  int failures = 0;
  bit m_last_d;          // most recent grant went to the dcache
  int m_i, m_d, m_c;     // expected counter values
  logic [ADDR_W:0] exp_q[$];  // {write, address} of expected pmem ops

  function automatic bit m_winner_is_d(input bit ireq, input bit dreq);
    if (ireq && dreq) return !m_last_d;
    return dreq;
  endfunction

  function automatic int m_sat_inc(input int v);
    return (v < CNT_MAX) ? v + 1 : CNT_MAX;
  endfunction

  function automatic void m_grant(input bit is_d, input bit both);
    m_last_d = is_d;
    if (is_d) m_d = m_sat_inc(m_d);
    else      m_i = m_sat_inc(m_i);
    if (both) m_c = m_sat_inc(m_c);
  endfunction

  function automatic void m_clear_counts();
    m_i = 0; m_d = 0; m_c = 0;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  // Entered at posedge+1 with requests driven; returns at the negedge of the
  // first strobe cycle. lat counts cycles from the request cycle (-1 = none).
  task automatic observe_strobe(output int lat, output logic rd, output logic wr,
                                output logic [ADDR_W-1:0] a, output logic [LINE_W-1:0] wd);
    lat = -1; rd = 1'b0; wr = 1'b0; a = '0; wd = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pmem_read || pmem_write) begin
        lat = k; rd = pmem_read; wr = pmem_write; a = pmem_address; wd = pmem_wdata;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) @(negedge clk);
  endtask

  // Entered at the negedge of the first strobe cycle; pulses pmem_resp
  // 'delay' cycles later and returns at posedge+1 of the following cycle.
  task automatic respond(input int delay, input logic [LINE_W-1:0] data,
                         output logic ir, output logic dr,
                         output logic [LINE_W-1:0] ird, output logic [LINE_W-1:0] drd);
    repeat (delay) @(negedge clk);
    pmem_rdata = data;
    pmem_resp  = 1'b1;
    #1;
    ir = i_mem_resp; dr = d_mem_resp; ird = i_mem_rdata; drd = d_mem_rdata;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    pmem_resp = 1'b1;
    pmem_rdata = rand_line();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({pmem_read, pmem_write} !== 2'b00) begin failures++; $display("FAIL reset_strobes: got %b exp 00", {pmem_read, pmem_write}); end
    checks++; if ({i_mem_resp, d_mem_resp} !== 2'b00) begin failures++; $display("FAIL reset_resp: got %b exp 00", {i_mem_resp, d_mem_resp}); end
    checks++; if (pmem_address !== '0) begin failures++; $display("FAIL reset_addr: got %h exp 0", pmem_address); end
    checks++; if (pmem_wdata !== '0) begin failures++; $display("FAIL reset_wdata: got %h exp 0", pmem_wdata); end
    checks++; if ({perf_i_grants, perf_d_grants, perf_conflicts} !== '0) begin failures++; $display("FAIL reset_counters: got %h %h %h exp 0", perf_i_grants, perf_d_grants, perf_conflicts); end
    @(posedge clk); #1;
    reset = 1'b0;
    pmem_resp = 1'b0;
    m_last_d = 1'b0;
    m_clear_counts();
  endtask

  task automatic test_i_only();
    int lat; logic rd, wr, ir, dr; logic [ADDR_W-1:0] a; logic [LINE_W-1:0] wd, ird, drd;
    logic [LINE_W-1:0] line;
    line = {16{8'hA5}};
    i_mem_read = 1'b1; i_mem_address = 16'h1230;
    m_grant(1'b0, 1'b0);
    observe_strobe(lat, rd, wr, a, wd);
    checks++; if (lat != 1) begin failures++; $display("FAIL i_only_latency: got %0d exp 1", lat); end
    checks++; if ({rd, wr} !== 2'b10) begin failures++; $display("FAIL i_only_op: got %b exp 10", {rd, wr}); end
    checks++; if (a !== 16'h1230) begin failures++; $display("FAIL i_only_addr: got %h exp 1230", a); end
    respond(3, line, ir, dr, ird, drd);
    checks++; if ({ir, dr} !== 2'b10) begin failures++; $display("FAIL i_only_resp: got %b exp 10", {ir, dr}); end
    checks++; if (ird !== line) begin failures++; $display("FAIL i_only_rdata: got %h exp %h", ird, line); end
    i_mem_read = 1'b0;
    @(negedge clk);
    checks++; if ({i_mem_resp, d_mem_resp, pmem_read, pmem_write} !== 4'b0) begin failures++; $display("FAIL i_only_after: got %b exp 0000", {i_mem_resp, d_mem_resp, pmem_read, pmem_write}); end
    checks++; if (perf_i_grants !== CNT_W'(m_i)) begin failures++; $display("FAIL i_only_count: got %0d exp %0d", perf_i_grants, m_i); end
    @(posedge clk); #1;
  endtask

  task automatic test_conflict();
    int lat; logic rd, wr, ir, dr; logic [ADDR_W-1:0] a; logic [LINE_W-1:0] wd, ird, drd;
    logic [ADDR_W-1:0] ia, da, da2; logic [LINE_W-1:0] wd2;
    bit w;
    ia = 16'($urandom); da = 16'($urandom); da2 = 16'($urandom); wd2 = rand_line();
    i_mem_read = 1'b1; i_mem_address = ia;
    d_mem_read = 1'b1; d_mem_write = 1'b0; d_mem_address = da;
    w = m_winner_is_d(1'b1, 1'b1); m_grant(w, 1'b1);
    observe_strobe(lat, rd, wr, a, wd);
    checks++; if (lat != 1) begin failures++; $display("FAIL conflict1_latency: got %0d exp 1", lat); end
    checks++; if (a !== (w ? da : ia)) begin failures++; $display("FAIL conflict1_addr: got %h exp %h", a, (w ? da : ia)); end
    respond(1, rand_line(), ir, dr, ird, drd);
    checks++; if ({ir, dr} !== {!w, w}) begin failures++; $display("FAIL conflict1_resp: got %b exp %b", {ir, dr}, {!w, w}); end
    // The dcache immediately issues a writeback while the icache still waits.
    d_mem_read = 1'b0; d_mem_write = 1'b1; d_mem_address = da2; d_mem_wdata = wd2;
    w = m_winner_is_d(1'b1, 1'b1); m_grant(w, 1'b1);
    observe_strobe(lat, rd, wr, a, wd);
    checks++; if (lat != 1) begin failures++; $display("FAIL conflict2_latency: got %0d exp 1", lat); end
    checks++; if ({a, rd, wr} !== (w ? {da2, 2'b01} : {ia, 2'b10})) begin failures++; $display("FAIL conflict2_op: got %h/%b%b exp winner_d=%0d", a, rd, wr, w); end
    respond(2, rand_line(), ir, dr, ird, drd);
    checks++; if ({ir, dr} !== {!w, w}) begin failures++; $display("FAIL conflict2_resp: got %b exp %b", {ir, dr}, {!w, w}); end
    i_mem_read = 1'b0;
    m_grant(1'b1, 1'b0);
    observe_strobe(lat, rd, wr, a, wd);
    checks++; if ({lat == 1, a, rd, wr} !== {1'b1, da2, 2'b01}) begin failures++; $display("FAIL conflict3_op: got lat=%0d %h %b%b exp lat=1 %h 01", lat, a, rd, wr, da2); end
    checks++; if (wd !== wd2) begin failures++; $display("FAIL conflict3_wdata: got %h exp %h", wd, wd2); end
    respond(0, rand_line(), ir, dr, ird, drd);
    checks++; if ({ir, dr} !== 2'b01) begin failures++; $display("FAIL conflict3_resp: got %b exp 01", {ir, dr}); end
    d_mem_write = 1'b0;
    @(negedge clk);
    checks++; if (perf_conflicts !== CNT_W'(m_c)) begin failures++; $display("FAIL conflict_count: got %0d exp %0d", perf_conflicts, m_c); end
    checks++; if ({perf_i_grants, perf_d_grants} !== {CNT_W'(m_i), CNT_W'(m_d)}) begin failures++; $display("FAIL conflict_grants: got %0d/%0d exp %0d/%0d", perf_i_grants, perf_d_grants, m_i, m_d); end
    @(posedge clk); #1;
  endtask

  task automatic test_d_write();
    int lat; logic rd, wr, ir, dr; logic [ADDR_W-1:0] a; logic [LINE_W-1:0] wd, ird, drd;
    logic [LINE_W-1:0] line;
    line = {8{16'hDEAD}};
    d_mem_write = 1'b1; d_mem_address = 16'h4000; d_mem_wdata = line;
    m_grant(1'b1, 1'b0);
    observe_strobe(lat, rd, wr, a, wd);
    checks++; if ({lat == 1, rd, wr} !== 3'b101) begin failures++; $display("FAIL d_write_op: got lat=%0d %b%b exp lat=1 01", lat, rd, wr); end
    checks++; if (a !== 16'h4000) begin failures++; $display("FAIL d_write_addr: got %h exp 4000", a); end
    checks++; if (wd !== line) begin failures++; $display("FAIL d_write_wdata: got %h exp %h", wd, line); end
    respond($urandom_range(0, 2), rand_line(), ir, dr, ird, drd);
    checks++; if ({ir, dr} !== 2'b01) begin failures++; $display("FAIL d_write_resp: got %b exp 01", {ir, dr}); end
    d_mem_write = 1'b0;
    @(negedge clk);
    checks++; if ({i_mem_resp, d_mem_resp, pmem_read, pmem_write} !== 4'b0) begin failures++; $display("FAIL d_write_after: got %b exp 0000", {i_mem_resp, d_mem_resp, pmem_read, pmem_write}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_serve();
    int lat; logic rd, wr, ir, dr; logic [ADDR_W-1:0] a, ia; logic [LINE_W-1:0] wd, ird, drd, line;
    d_mem_read = 1'b1; d_mem_address = 16'($urandom);
    observe_strobe(lat, rd, wr, a, wd);
    checks++; if ({lat == 1, rd} !== 2'b11) begin failures++; $display("FAIL midrst_strobe: got lat=%0d rd=%b exp lat=1 rd=1", lat, rd); end
    @(posedge clk); #1;
    reset = 1'b1; d_mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_last_d = 1'b0; m_clear_counts();
    pmem_resp = 1'b1; pmem_rdata = rand_line();
    @(negedge clk);
    checks++; if ({i_mem_resp, d_mem_resp} !== 2'b00) begin failures++; $display("FAIL midrst_stale_resp: got %b exp 00", {i_mem_resp, d_mem_resp}); end
    checks++; if ({pmem_read, pmem_write} !== 2'b00) begin failures++; $display("FAIL midrst_strobes: got %b exp 00", {pmem_read, pmem_write}); end
    checks++; if (pmem_address !== '0) begin failures++; $display("FAIL midrst_addr: got %h exp 0", pmem_address); end
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    ia = 16'($urandom); line = rand_line();
    i_mem_read = 1'b1; i_mem_address = ia;
    m_grant(1'b0, 1'b0);
    observe_strobe(lat, rd, wr, a, wd);
    checks++; if ({lat == 1, rd, wr, a} !== {3'b110, ia}) begin failures++; $display("FAIL midrst_next_op: got lat=%0d %b%b %h exp lat=1 10 %h", lat, rd, wr, a, ia); end
    respond(1, line, ir, dr, ird, drd);
    checks++; if ({ir, dr, ird} !== {2'b10, line}) begin failures++; $display("FAIL midrst_next_resp: got %b%b %h exp 10 %h", ir, dr, ird, line); end
    i_mem_read = 1'b0;
    @(negedge clk);
    checks++; if (perf_i_grants !== CNT_W'(m_i)) begin failures++; $display("FAIL midrst_count: got %0d exp %0d", perf_i_grants, m_i); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int lat; logic rd, wr, ir, dr; logic [ADDR_W-1:0] a; logic [LINE_W-1:0] wd, ird, drd;
    perf_clear = 1'b1;
    @(posedge clk); #1;
    perf_clear = 1'b0;
    m_clear_counts();
    for (int k = 0; k < CNT_MAX + 2; k++) begin
      i_mem_read = 1'b1; i_mem_address = 16'($urandom);
      m_grant(1'b0, 1'b0);
      observe_strobe(lat, rd, wr, a, wd);
      checks++; if (lat != 1) begin failures++; $display("FAIL sat_latency k=%0d: got %0d exp 1", k, lat); end
      respond(0, rand_line(), ir, dr, ird, drd);
      i_mem_read = 1'b0;
      @(negedge clk);
      if (k == CNT_MAX - 2 || k == CNT_MAX + 1) begin
        checks++; if (perf_i_grants !== CNT_W'(m_i)) begin failures++; $display("FAIL sat_count k=%0d: got %0d exp %0d", k, perf_i_grants, m_i); end
      end
      @(posedge clk); #1;
    end
    // Grant and clear in the same cycle: clear must win.
    i_mem_read = 1'b1; i_mem_address = 16'($urandom); perf_clear = 1'b1;
    m_grant(1'b0, 1'b0); m_clear_counts();
    @(posedge clk); #1;
    perf_clear = 1'b0;
    @(negedge clk);
    checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL sat_clear_grant: got %b exp 1", pmem_read); end
    checks++; if ({perf_i_grants, perf_d_grants, perf_conflicts} !== {CNT_W'(m_i), CNT_W'(m_d), CNT_W'(m_c)}) begin failures++; $display("FAIL sat_clear: got %0d %0d %0d exp %0d %0d %0d", perf_i_grants, perf_d_grants, perf_conflicts, m_i, m_d, m_c); end
    respond(0, rand_line(), ir, dr, ird, drd);
    i_mem_read = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat; logic rd, wr, ir, dr; logic [ADDR_W-1:0] a; logic [LINE_W-1:0] wd, ird, drd;
    bit ops[3]; logic [ADDR_W-1:0] addrs[3]; logic [ADDR_W:0] exp_op;
    ops[0] = 1'b0; ops[1] = 1'b1; ops[2] = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      addrs[k] = 16'($urandom);
      exp_q.push_back({ops[k], addrs[k]});
    end
    d_mem_read = !ops[0]; d_mem_write = ops[0]; d_mem_address = addrs[0];
    for (int k = 0; k < 3; k++) begin
      m_grant(1'b1, 1'b0);
      observe_strobe(lat, rd, wr, a, wd);
      exp_op = exp_q.pop_front();
      checks++; if (lat != 1) begin failures++; $display("FAIL b2b_gap k=%0d: got lat %0d exp 1", k, lat); end
      checks++; if ({rd, wr, a} !== {!exp_op[ADDR_W], exp_op}) begin failures++; $display("FAIL b2b_op k=%0d: got %b%b %h exp %b %h", k, rd, wr, a, exp_op[ADDR_W], exp_op[ADDR_W-1:0]); end
      respond($urandom_range(0, 3), rand_line(), ir, dr, ird, drd);
      checks++; if ({ir, dr} !== 2'b01) begin failures++; $display("FAIL b2b_resp k=%0d: got %b exp 01", k, {ir, dr}); end
      if (k < 2) begin
        d_mem_read = !ops[k+1]; d_mem_write = ops[k+1]; d_mem_address = addrs[k+1];
      end else begin
        d_mem_read = 1'b0; d_mem_write = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (perf_d_grants !== CNT_W'(m_d)) begin failures++; $display("FAIL b2b_count: got %0d exp %0d", perf_d_grants, m_d); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic rd, wr, ir, dr; logic [ADDR_W-1:0] a; logic [LINE_W-1:0] wd, ird, drd;
    bit ireq, dreq, dwr, first_d, srv_d, exp_w;
    logic [ADDR_W-1:0] ia, da, exp_a; logic [LINE_W-1:0] dwd, rdat;
    for (int r = 0; r < 30; r++) begin
      ireq = 1'($urandom_range(0, 1)); dreq = 1'($urandom_range(0, 1)); dwr = 1'($urandom_range(0, 1));
      if (!ireq && !dreq) ireq = 1'b1;
      ia = 16'($urandom); da = 16'($urandom); dwd = rand_line();
      i_mem_read = ireq; i_mem_address = ia;
      d_mem_read = dreq && !dwr; d_mem_write = dreq && dwr; d_mem_address = da; d_mem_wdata = dwd;
      first_d = m_winner_is_d(ireq, dreq);
      for (int t = 0; t < 2; t++) begin
        if (t == 1 && !(ireq && dreq)) break;
        srv_d = (t == 0) ? first_d : !first_d;
        m_grant(srv_d, (t == 0) && ireq && dreq);
        exp_a = srv_d ? da : ia;
        exp_w = srv_d && dwr;
        observe_strobe(lat, rd, wr, a, wd);
        checks++; if (lat != 1) begin failures++; $display("FAIL rnd_latency r=%0d t=%0d: got %0d exp 1", r, t, lat); end
        checks++; if ({rd, wr, a} !== {!exp_w, exp_w, exp_a}) begin failures++; $display("FAIL rnd_op r=%0d t=%0d: got %b%b %h exp %b%b %h", r, t, rd, wr, a, !exp_w, exp_w, exp_a); end
        if (exp_w) begin
          checks++; if (wd !== dwd) begin failures++; $display("FAIL rnd_wdata r=%0d: got %h exp %h", r, wd, dwd); end
        end
        rdat = rand_line();
        respond($urandom_range(0, 3), rdat, ir, dr, ird, drd);
        checks++; if ({ir, dr} !== {!srv_d, srv_d}) begin failures++; $display("FAIL rnd_resp r=%0d t=%0d: got %b exp %b", r, t, {ir, dr}, {!srv_d, srv_d}); end
        checks++; if ((srv_d ? drd : ird) !== rdat) begin failures++; $display("FAIL rnd_rdata r=%0d t=%0d: got %h exp %h", r, t, (srv_d ? drd : ird), rdat); end
        if (srv_d) begin d_mem_read = 1'b0; d_mem_write = 1'b0; end
        else i_mem_read = 1'b0;
      end
      @(negedge clk);
      checks++; if ({pmem_read, pmem_write, i_mem_resp, d_mem_resp} !== 4'b0) begin failures++; $display("FAIL rnd_idle r=%0d: got %b exp 0000", r, {pmem_read, pmem_write, i_mem_resp, d_mem_resp}); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if ({perf_i_grants, perf_d_grants, perf_conflicts} !== {CNT_W'(m_i), CNT_W'(m_d), CNT_W'(m_c)}) begin failures++; $display("FAIL rnd_counters: got %0d %0d %0d exp %0d %0d %0d", perf_i_grants, perf_d_grants, perf_conflicts, m_i, m_d, m_c); end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; perf_clear = 1'b0;
    i_mem_read = 1'b0; i_mem_address = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_i_only();
    test_conflict();
    test_d_write();
    test_reset_mid_serve();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
